memory_access_stage: RTL and testbench

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

---
 rtl/memory_access_stage.sv | 164 ++++++++++++++++
 tb/tb_memory_access_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: forwards ALU results in one cycle, runs one data-memory transaction per load/store.
// Results appear the cycle after accept (or after ack); h_o_stall holds upstream while waiting for ack or when downstream stalls.
module memory_access_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              h_clk,
  input  logic              h_rst_n,
  input  logic              h_i_ce,
  input  logic              h_i_we_reg,
  input  logic [AWIDTH-1:0] h_i_addr_rd,
  input  logic [DWIDTH-1:0] h_i_alu_result,
  input  logic [DWIDTH-1:0] h_i_rs2_data,
  input  logic              h_i_is_load,
  input  logic              h_i_is_store,
  input  logic [2:0]        h_i_funct3,
  input  logic              h_i_stall,
  input  logic              h_i_flush,
  output logic              h_o_stall,
  output logic              h_o_ce,
  output logic              h_o_we_reg,
  output logic [AWIDTH-1:0] h_o_addr_rd,
  output logic [DWIDTH-1:0] h_o_data_rd,
  output logic              h_o_misaligned,
  output logic              h_o_req,
  output logic              h_o_wr,
  output logic [DWIDTH-1:0] h_o_addr,
  output logic [DWIDTH-1:0] h_o_wdata,
  output logic [3:0]        h_o_sel,
  input  logic              h_i_ack,
  input  logic [DWIDTH-1:0] h_i_rdata
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic                is_mem, misaligned_c, go_mem;
  logic [1:0]          lane;
  logic [3:0]          sel_c;
  logic [DWIDTH-1:0]   wdata_c, shifted, load_data;
  logic                we_q, store_q, flushed_q;
  logic [AWIDTH-1:0]   rd_q;
  logic [2:0]          f3_q;
  logic [1:0]          lane_q;

  assign lane         = h_i_alu_result[1:0];
  assign is_mem       = h_i_is_load | h_i_is_store;
  assign misaligned_c = is_mem & (((h_i_funct3[1:0] == 2'b01) & lane[0]) |
                                  ((h_i_funct3[1:0] == 2'b10) & (lane != 2'b00)));
  assign go_mem       = is_mem & ~misaligned_c;

  always_ff @(posedge h_clk or negedge h_rst_n) begin
    if (!h_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (h_i_ce && !h_i_stall && !h_i_flush && go_mem) state_d = S_WAIT;
      S_WAIT: if (h_i_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    h_o_stall = (state_q == S_WAIT) | h_i_stall;
  end

  // Store lane steering; loads reuse the same byte-enable pattern.
  always_comb begin
    sel_c   = 4'b1111;
    wdata_c = h_i_rs2_data;
    case (h_i_funct3[1:0])
      2'b00: begin
        sel_c   = 4'b0001 << lane;
        wdata_c = {(DWIDTH/8){h_i_rs2_data[7:0]}};
      end
      2'b01: begin
        sel_c   = 4'b0011 << {lane[1], 1'b0};
        wdata_c = {(DWIDTH/16){h_i_rs2_data[15:0]}};
      end
      default: begin
        sel_c   = 4'b1111;
        wdata_c = h_i_rs2_data;
      end
    endcase
  end

  always_comb begin
    shifted   = h_i_rdata >> {lane_q, 3'b000};
    load_data = h_i_rdata;
    case (f3_q)
      3'b000:  load_data = {{(DWIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{(DWIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {{(DWIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  load_data = {{(DWIDTH-16){1'b0}}, shifted[15:0]};
      default: load_data = h_i_rdata;
    endcase
  end

  always_ff @(posedge h_clk or negedge h_rst_n) begin
    if (!h_rst_n) begin
      h_o_ce         <= 1'b0;
      h_o_we_reg     <= 1'b0;
      h_o_addr_rd    <= '0;
      h_o_data_rd    <= '0;
      h_o_misaligned <= 1'b0;
      h_o_req        <= 1'b0;
      h_o_wr         <= 1'b0;
      h_o_addr       <= '0;
      h_o_wdata      <= '0;
      h_o_sel        <= '0;
      we_q           <= 1'b0;
      store_q        <= 1'b0;
      flushed_q      <= 1'b0;
      rd_q           <= '0;
      f3_q           <= '0;
      lane_q         <= '0;
    end else if (state_q == S_IDLE) begin
      // Flush beats stall; a downstream stall freezes the writeback outputs.
      if (h_i_flush) begin
        h_o_ce <= 1'b0;
      end else if (!h_i_stall) begin
        if (!h_i_ce) begin
          h_o_ce <= 1'b0;
        end else if (go_mem) begin
          h_o_ce         <= 1'b0;
          h_o_misaligned <= 1'b0;
          h_o_req        <= 1'b1;
          h_o_wr         <= h_i_is_store;
          h_o_addr       <= {h_i_alu_result[DWIDTH-1:2], 2'b00};
          h_o_wdata      <= wdata_c;
          h_o_sel        <= sel_c;
          we_q           <= h_i_we_reg;
          store_q        <= h_i_is_store;
          rd_q           <= h_i_addr_rd;
          f3_q           <= h_i_funct3;
          lane_q         <= lane;
          flushed_q      <= 1'b0;
        end else begin
          h_o_ce         <= 1'b1;
          h_o_misaligned <= misaligned_c;
          h_o_we_reg     <= h_i_we_reg & ~misaligned_c;
          h_o_addr_rd    <= h_i_addr_rd;
          h_o_data_rd    <= h_i_alu_result;
        end
      end
    end else begin
      if (h_i_flush) flushed_q <= 1'b1;
      if (h_i_ack) begin
        h_o_req        <= 1'b0;
        h_o_wr         <= 1'b0;
        h_o_ce         <= ~(flushed_q | h_i_flush);
        h_o_misaligned <= 1'b0;
        h_o_addr_rd    <= rd_q;
        h_o_we_reg     <= we_q & ~store_q;
        if (!store_q) h_o_data_rd <= load_data;
        flushed_q      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Randomized bench for memory_access_stage against a transaction-level reference model.
module tb_memory_access_stage;

  logic        h_clk = 1'b0;
  logic        h_rst_n = 1'b1;
  logic        h_i_ce = 0, h_i_we_reg = 0, h_i_is_load = 0, h_i_is_store = 0;
  logic [4:0]  h_i_addr_rd = 0;
  logic [31:0] h_i_alu_result = 0, h_i_rs2_data = 0, h_i_rdata = 0;
  logic [2:0]  h_i_funct3 = 0;
  logic        h_i_stall = 0, h_i_flush = 0, h_i_ack = 0;
  logic        h_o_stall, h_o_ce, h_o_we_reg, h_o_misaligned, h_o_req, h_o_wr;
  logic [4:0]  h_o_addr_rd;
  logic [31:0] h_o_data_rd, h_o_addr, h_o_wdata;
  logic [3:0]  h_o_sel;

  int n_chk = 0;
  int n_err = 0;

  memory_access_stage #(.DWIDTH(32), .AWIDTH(5)) dut (
    .h_clk(h_clk), .h_rst_n(h_rst_n), .h_i_ce(h_i_ce), .h_i_we_reg(h_i_we_reg),
    .h_i_addr_rd(h_i_addr_rd), .h_i_alu_result(h_i_alu_result), .h_i_rs2_data(h_i_rs2_data),
    .h_i_is_load(h_i_is_load), .h_i_is_store(h_i_is_store), .h_i_funct3(h_i_funct3),
    .h_i_stall(h_i_stall), .h_i_flush(h_i_flush), .h_o_stall(h_o_stall), .h_o_ce(h_o_ce),
    .h_o_we_reg(h_o_we_reg), .h_o_addr_rd(h_o_addr_rd), .h_o_data_rd(h_o_data_rd),
    .h_o_misaligned(h_o_misaligned), .h_o_req(h_o_req), .h_o_wr(h_o_wr), .h_o_addr(h_o_addr),
    .h_o_wdata(h_o_wdata), .h_o_sel(h_o_sel), .h_i_ack(h_i_ack), .h_i_rdata(h_i_rdata)
  );

  always #5 h_clk = ~h_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic ref_mis(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a);
    int size = int'(f3) % 4;
    if (!(ld || st)) return 1'b0;
    return (size == 1 && a % 2 != 0) || (size == 2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v = w >> (8 * (a % 4));
    logic [31:0] b = v % 256;
    logic [31:0] h = v % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_sel(input logic [2:0] f3, input logic [31:0] a);
    case (int'(f3) % 4)
      0:       return 32'd1 << (a % 4);
      1:       return 32'd3 << (a % 4);
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (int'(f3) % 4)
      0:       return (d % 256) * 32'h0101_0101;
      1:       return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Issue one instruction from IDLE, answer the bus after dly wait cycles, check the result.
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic we,
                        input int dly, input logic [31:0] rdat, input logic fl);
    logic mis;
    mis = ref_mis(ld, st, f3, a);
    h_i_ce = 1; h_i_is_load = ld; h_i_is_store = st; h_i_funct3 = f3;
    h_i_alu_result = a; h_i_rs2_data = rs2; h_i_addr_rd = rd; h_i_we_reg = we;
    @(posedge h_clk); #1;
    h_i_ce = 0; h_i_is_load = 0; h_i_is_store = 0;
    if (!(ld || st) || mis) begin
      check("ce", h_o_ce, 1);
      check("req_none", h_o_req, 0);
      check("misaligned", h_o_misaligned, mis);
      check("addr_rd", h_o_addr_rd, rd);
      check("we_reg", h_o_we_reg, mis ? 1'b0 : we);
      if (!mis) check("alu_data", h_o_data_rd, a);
    end else begin
      check("req", h_o_req, 1);
      check("wr", h_o_wr, st);
      check("ce_pending", h_o_ce, 0);
      if (st) begin
        check("sel", h_o_sel, ref_sel(f3, a));
        check("wdata", h_o_wdata, ref_wdata(f3, rs2));
      end
      for (int c = 0; c <= dly; c++) begin
        check("stall_wait", h_o_stall, 1);
        check("addr_hold", h_o_addr, a & 32'hFFFF_FFFC);
        if (fl && c == 0) h_i_flush = 1;
        if (c == dly) begin h_i_ack = 1; h_i_rdata = rdat; end
        @(posedge h_clk); #1;
        h_i_flush = 0; h_i_ack = 0; h_i_rdata = $urandom;
      end
      check("req_done", h_o_req, 0);
      check("stall_done", h_o_stall, 0);
      check("ce_done", h_o_ce, !fl);
      if (!fl) begin
        check("rd_done", h_o_addr_rd, rd);
        check("we_done", h_o_we_reg, st ? 1'b0 : we);
        check("mis_done", h_o_misaligned, 0);
        if (ld) check("load_data", h_o_data_rd, ref_load(f3, a, rdat));
      end
    end
    @(posedge h_clk); #1;
    check("ce_idle", h_o_ce, 0);
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    logic [2:0] st_f3 [3];
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    st_f3 = '{3'd0, 3'd1, 3'd2};

    #2 h_rst_n = 0; h_i_stall = 1;
    #10;
    check("rst_ce", h_o_ce, 0);
    check("rst_req", h_o_req, 0);
    check("rst_data", h_o_data_rd, 0);
    check("rst_addr", h_o_addr, 0);
    check("rst_sel", h_o_sel, 0);
    check("rst_stall_pass", h_o_stall, 1);
    h_i_stall = 0;
    @(negedge h_clk); h_rst_n = 1;
    @(posedge h_clk); #1;

    run_op(0, 0, 3'd0, 32'h0000_1234, 0, 5'd5, 1, 0, 0, 0);
    run_op(1, 0, 3'd0, 32'h0000_0103, 0, 5'd7, 1, 2, 32'h80FF_0000, 0);
    run_op(0, 1, 3'd1, 32'h0000_0022, 32'h0000_ABCD, 5'd0, 1, 1, 0, 0);
    run_op(1, 0, 3'd2, 32'h0000_0041, 0, 5'd9, 1, 0, 0, 0);
    run_op(1, 0, 3'd5, 32'h0000_0002, 0, 5'd4, 1, 1, 32'h8001_0000, 1);
    run_op(1, 0, 3'd5, 32'h0000_0002, 0, 5'd4, 1, 1, 32'h8001_0000, 0);

    // Downstream stall holds the last result and blocks acceptance.
    h_i_ce = 1; h_i_alu_result = 32'hAAAA; h_i_addr_rd = 5'd3; h_i_we_reg = 1; h_i_funct3 = 0;
    @(posedge h_clk); #1;
    check("pre_stall", h_o_data_rd, 32'hAAAA);
    h_i_stall = 1; h_i_alu_result = 32'hBBBB;
    repeat (2) begin
      @(posedge h_clk); #1;
      check("stall_ce_hold", h_o_ce, 1);
      check("stall_data_hold", h_o_data_rd, 32'hAAAA);
      check("stall_out", h_o_stall, 1);
    end
    h_i_stall = 0;
    @(posedge h_clk); #1;
    check("post_stall", h_o_data_rd, 32'hBBBB);
    h_i_alu_result = 32'hCCCC; h_i_flush = 1;
    @(posedge h_clk); #1;
    check("flush_idle_ce", h_o_ce, 0);
    h_i_flush = 0; h_i_ce = 0; h_i_ack = 1;
    @(posedge h_clk); #1;
    h_i_ack = 0;
    check("ack_idle_ce", h_o_ce, 0);
    check("ack_idle_req", h_o_req, 0);

    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 2);
      logic [2:0] f3;
      f3 = (kind == 1) ? ld_f3[$urandom_range(0, 4)] :
           (kind == 2) ? st_f3[$urandom_range(0, 2)] : 3'($urandom);
      run_op(kind == 1, kind == 2, f3, $urandom, $urandom, 5'($urandom), 1'($urandom),
             $urandom_range(0, 3), $urandom, $urandom_range(0, 5) == 0);
    end

    // Reset during WAIT abandons the access.
    h_i_ce = 1; h_i_is_load = 1; h_i_funct3 = 3'd2; h_i_alu_result = 32'h80; h_i_addr_rd = 5'd6;
    @(posedge h_clk); #1;
    h_i_ce = 0; h_i_is_load = 0;
    check("rw_req", h_o_req, 1);
    @(posedge h_clk); #1;
    h_rst_n = 0; #1;
    check("rw_req_drop", h_o_req, 0);
    check("rw_ce", h_o_ce, 0);
    check("rw_addr", h_o_addr, 0);
    check("rw_stall", h_o_stall, 0);
    @(negedge h_clk); h_rst_n = 1; h_i_ack = 1; h_i_rdata = 32'h1234_5678;
    @(posedge h_clk); #1;
    h_i_ack = 0;
    check("rw_after_ce", h_o_ce, 0);
    check("rw_after_data", h_o_data_rd, 0);
    check("rw_after_req", h_o_req, 0);
    @(posedge h_clk); #1;
    check("rw_after_ce2", h_o_ce, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
